iter_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 8 +
 rtl/shift_step.sv | 24 ++
 rtl/iter_shifter.sv | 83 ++++++++
 tb/tb_iter_shifter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: shift-mode encodings and FSM states shared by the iterative shifter.
package shifter_pkg;
    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift of data by k positions (k <= WIDTH) in the given mode.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] k,
    input  logic [1:0]       mode,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);
    logic [WIDTH-1:0] fill;
    always_comb begin
        // SRA fill: ones in the top k bits when the operand is negative
        fill   = sign ? ~({WIDTH{1'b1}} >> k) : '0;
        result = mode == MODE_SLL ? data << k :
                 mode == MODE_SRL ? data >> k :
                 mode == MODE_SRA ? (data >> k) | fill :
                                    (data << k) | (data >> (W_AMT - k));
    end
endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle SLL/SRL/SRA/ROL unit, up to STEP positions per clock,
// with valid/ready handshakes on both request and result ports.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [$clog2(WIDTH):0] in_amt,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   busy
);
    localparam int AMT_W = $clog2(WIDTH) + 1;
    localparam logic [AMT_W-1:0] W_AMT    = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [1:0]       mode_q, mode_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] eff_amt, k;
    logic [WIDTH-1:0] step_out;

    shift_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
        .data  (work_q),
        .k     (k),
        .mode  (mode_q),
        .sign  (work_q[WIDTH-1]),
        .result(step_out)
    );

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_data  = work_q;

    always_comb begin
        // rotates reduce modulo WIDTH; other modes saturate at WIDTH
        eff_amt = in_mode == MODE_ROL ? (in_amt & (W_AMT - 1'b1)) :
                  in_amt > W_AMT ? W_AMT : in_amt;
        k       = rem_q < STEP_AMT ? rem_q : STEP_AMT;
        state_d = state_q;
        work_d  = work_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (in_valid) begin
                work_d  = in_data;
                mode_d  = in_mode;
                rem_d   = eff_amt;
                state_d = eff_amt == '0 ? DONE : SHIFT;
            end
            SHIFT: begin
                work_d  = step_out;
                rem_d   = rem_q - k;
                state_d = rem_d == '0 ? DONE : SHIFT;
            end
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            mode_q  <= MODE_SLL;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: randomized and directed checks of iter_shifter (WIDTH=8, STEP=3)
// against an arithmetic reference model.
module tb_iter_shifter;
    localparam int W  = 8;
    localparam int ST = 3;
    localparam int AW = $clog2(W) + 1;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
    logic [W-1:0]  in_data = 0, out_data;
    logic [AW-1:0] in_amt = 0;
    logic [1:0]    in_mode = 0;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(W), .STEP(ST)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    function automatic int eff_of(input int a, input int m);
        return m == 3 ? a % W : (a > W ? W : a);
    endfunction

    function automatic int lat_of(input int a, input int m);
        return 1 + (eff_of(a, m) + ST - 1) / ST;
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a, input int m);
        logic [2*W-1:0] t;
        case (m)
            0: return a >= W ? '0 : d << a;
            1: return a >= W ? '0 : d >> a;
            2: return a >= W ? {W{d[W-1]}} : W'($signed(d) >>> a);
            default: begin
                t = {d, d} << (a % W);
                return t[2*W-1:W];
            end
        endcase
    endfunction

    // Issues one request from IDLE and waits (bounded) for the result.
    task automatic run_op(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] m,
                          output int lat, output logic [W-1:0] res, output logic bsy);
        in_data = d; in_amt = a; in_mode = m; in_valid = 1;
        @(posedge clk); #1;
        bsy = busy;
        in_valid = 0; in_data = W'($urandom); in_amt = AW'($urandom); in_mode = 2'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid) begin lat = i; break; end
            @(posedge clk); #1;
        end
        res = out_data;
    endtask

    task automatic handshake(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== 0 || out_data !== 0 || busy !== 0 || in_ready !== 1) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h busy=%b ready=%b, want 0 00 0 1", out_valid, out_data, busy, in_ready);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [W-1:0] ds[5] = '{8'h81, 8'h96, 8'h81, 8'h81, 8'h5A};
        int as[5] = '{7, 0, 9, 9, 12};
        int ms[5] = '{1, 0, 2, 3, 0};
        int lat; logic [W-1:0] res; logic bsy;
        for (int i = 0; i < 5; i++) begin
            run_op(ds[i], AW'(as[i]), 2'(ms[i]), lat, res, bsy);
            checks++;
            if (lat !== lat_of(as[i], ms[i]) || res !== model(ds[i], as[i], ms[i]) || bsy !== 1) begin
                errors++;
                $display("FAIL directed%0d: lat=%0d data=%h busy=%b, want lat=%0d data=%h busy=1",
                         i, lat, res, bsy, lat_of(as[i], ms[i]), model(ds[i], as[i], ms[i]));
            end
            if (i == 0) begin
                checks++;
                if (res !== 8'h01 || lat !== 4) begin
                    errors++;
                    $display("FAIL srl81_7: data=%h lat=%0d, want 01 lat 4", res, lat);
                end
            end
            handshake(0);
        end
    endtask

    task automatic test_random;
        int lat; logic [W-1:0] d, res; int a, m; logic bsy;
        for (int n = 0; n < 60; n++) begin
            d = W'($urandom); a = $urandom_range(0, 15); m = $urandom_range(0, 3);
            run_op(d, AW'(a), 2'(m), lat, res, bsy);
            checks++;
            if (lat !== lat_of(a, m) || res !== model(d, a, m)) begin
                errors++;
                $display("FAIL random: d=%h amt=%0d mode=%0d got lat=%0d data=%h, want lat=%0d data=%h",
                         d, a, m, lat, res, lat_of(a, m), model(d, a, m));
            end
            handshake($urandom_range(0, 2));
            checks++;
            if (out_valid !== 0 || in_ready !== 1) begin
                errors++;
                $display("FAIL post_handshake: valid=%b ready=%b, want 0 1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [W-1:0] res; logic bsy;
        run_op(8'hC3, 4'd5, 2'd2, lat, res, bsy);
        in_data = 8'h3C; in_amt = 4'd2; in_mode = 2'd3; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1 || out_data !== model(8'hC3, 5, 2) || in_ready !== 0) begin
                errors++;
                $display("FAIL hold%0d: valid=%b data=%h ready=%b, want 1 %h 0", i, out_valid, out_data, in_ready, model(8'hC3, 5, 2));
            end
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL release: valid=%b ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        in_valid = 0; in_data = 0; in_amt = 0; in_mode = 0;
        checks++;
        if (busy !== 1) begin
            errors++;
            $display("FAIL next_accept: busy=%b, want 1", busy);
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid) begin lat = i; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (lat !== lat_of(2, 3) || out_data !== model(8'h3C, 2, 3)) begin
            errors++;
            $display("FAIL queued_op: lat=%0d data=%h, want lat=%0d data=%h", lat, out_data, lat_of(2, 3), model(8'h3C, 2, 3));
        end
        handshake(0);
    endtask

    task automatic test_reset_mid;
        int seen = 0; int lat; logic [W-1:0] res; logic bsy;
        in_data = 8'hA5; in_amt = 4'd8; in_mode = 2'd0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        checks++;
        if (out_valid !== 0 || out_data !== 0 || busy !== 0 || in_ready !== 1) begin
            errors++;
            $display("FAIL mid_reset: valid=%b data=%h busy=%b ready=%b, want 0 00 0 1", out_valid, out_data, busy, in_ready);
        end
        repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL aborted_result: %0d valid cycles, want 0", seen);
        end
        run_op(8'h0F, 4'd3, 2'd1, lat, res, bsy);
        checks++;
        if (lat !== lat_of(3, 1) || res !== model(8'h0F, 3, 1)) begin
            errors++;
            $display("FAIL after_reset: lat=%0d data=%h, want lat=%0d data=%h", lat, res, lat_of(3, 1), model(8'h0F, 3, 1));
        end
        handshake(0);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
